// File: rtl/ghost_pkg.sv
// ---------------------------------------------------------------------------
// ghost_pkg
// Shared definitions for the ghost direction scheduler:
//   - direction codes (0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT)
//   - bit positions inside the per-ghost open-path mask
//   - default number of ghost requesters
//   - scheduler FSM state type
//   - reverse_dir(): opposite direction of a code (NONE for NONE/invalid)
// ---------------------------------------------------------------------------
package ghost_pkg;

    localparam logic [3:0] DIR_NONE  = 4'd0;
    localparam logic [3:0] DIR_UP    = 4'd1;
    localparam logic [3:0] DIR_DOWN  = 4'd2;
    localparam logic [3:0] DIR_LEFT  = 4'd3;
    localparam logic [3:0] DIR_RIGHT = 4'd4;

    // Mask bit k corresponds to direction code k+1.
    localparam int MASK_UP    = 0;
    localparam int MASK_DOWN  = 1;
    localparam int MASK_LEFT  = 2;
    localparam int MASK_RIGHT = 3;

    localparam int N_GHOST_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_PICK   = 2'd2
    } state_e;

    // Codes 5..15 are treated as NONE, which has no opposite.
    function automatic logic [3:0] reverse_dir(input logic [3:0] d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ghost_dir_scheduler_if.sv
// ---------------------------------------------------------------------------
// ghost_dir_scheduler_if
// Request/grant bundle between the ghost requesters and the scheduler.
//   i_random   [3:0]          shared random source (bits [1:0] used)
//   i_req      [N_GHOST-1:0]  per-ghost level request
//   i_cur_dir  [4*N_GHOST-1:0] per-ghost current direction code
//   i_allowed  [4*N_GHOST-1:0] per-ghost open-path mask
//   o_dir_valid               one-cycle grant pulse
//   o_dir      [3:0]          chosen direction code
//   o_ghost_id [ID_W-1:0]     served ghost
//   o_ack      [N_GHOST-1:0]  one-hot acknowledge
//   o_busy                    scheduler not idle
// Modports: master (requester side), slave (scheduler side).
// ---------------------------------------------------------------------------
interface ghost_dir_scheduler_if #(
    parameter int N_GHOST = 4,
    parameter int ID_W    = $clog2(N_GHOST)
);
    logic [3:0]           i_random;
    logic [N_GHOST-1:0]   i_req;
    logic [4*N_GHOST-1:0] i_cur_dir;
    logic [4*N_GHOST-1:0] i_allowed;
    logic                 o_dir_valid;
    logic [3:0]           o_dir;
    logic [ID_W-1:0]      o_ghost_id;
    logic [N_GHOST-1:0]   o_ack;
    logic                 o_busy;

    modport master (
        output i_random, i_req, i_cur_dir, i_allowed,
        input  o_dir_valid, o_dir, o_ghost_id, o_ack, o_busy
    );

    modport slave (
        input  i_random, i_req, i_cur_dir, i_allowed,
        output o_dir_valid, o_dir, o_ghost_id, o_ack, o_busy
    );
endinterface

// File: rtl/ghost_dir_picker.sv
// ---------------------------------------------------------------------------
// ghost_dir_picker
// Combinational direction choice for one latched ghost.
//   start_i   [1:0]  scan start index (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT)
//   allowed_i [3:0]  open-path mask
//   cur_dir_i [3:0]  current direction code
//   dir_o     [3:0]  chosen direction code (NONE when mask is empty)
// Macro GHOST_NO_REVERSE_EN: when defined, the reverse of cur_dir_i is
// skipped during the scan and only taken if it is the sole open path.
// ---------------------------------------------------------------------------
module ghost_dir_picker
    import ghost_pkg::*;
(
    input  logic [1:0] start_i,
    input  logic [3:0] allowed_i,
    input  logic [3:0] cur_dir_i,
    output logic [3:0] dir_o
);

`ifdef GHOST_NO_REVERSE_EN
    logic [3:0] rev;
`else
    logic unused_cur_dir;
    assign unused_cur_dir = ^cur_dir_i;
`endif
    logic       found;
    logic [1:0] k;
    logic [3:0] code;
    logic       excl;

    // Rotating scan from the random start index; the first open,
    // non-excluded direction wins.
    always_comb begin
        found = 1'b0;
        dir_o = DIR_NONE;
        k     = 2'd0;
        code  = DIR_NONE;
        excl  = 1'b0;
`ifdef GHOST_NO_REVERSE_EN
        rev   = reverse_dir(cur_dir_i);
`endif
        for (int j = 0; j < 4; j++) begin
            k    = start_i + 2'(j);
            code = {2'b00, k} + 4'd1;
`ifdef GHOST_NO_REVERSE_EN
            excl = (code == rev);
`else
            excl = 1'b0;
`endif
            if (!found && allowed_i[k] && !excl) begin
                found = 1'b1;
                dir_o = code;
            end
        end
`ifdef GHOST_NO_REVERSE_EN
        // Nothing but the reverse is open: a dead end, so turn around.
        if (!found && (allowed_i != 4'd0)) begin
            dir_o = rev;
        end
`endif
    end

endmodule

// File: rtl/ghost_dir_scheduler.sv
// ---------------------------------------------------------------------------
// ghost_dir_scheduler
// Serves ghost direction requests one at a time, round-robin, picking a
// pseudo-random open direction for each. One grant every 3 cycles at most.
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   bus    ghost_dir_scheduler_if.slave (requests in, grant pulse out)
// FSM: IDLE (arbitrate + latch ghost) -> SAMPLE (latch random start)
//      -> PICK (register result, pulse valid/ack) -> IDLE.
// Macro GHOST_NO_REVERSE_EN: enables reverse-direction exclusion in the
// picker (see ghost_dir_picker).
// ---------------------------------------------------------------------------
module ghost_dir_scheduler
    import ghost_pkg::*;
#(
    parameter int N_GHOST = N_GHOST_DEFAULT,
    parameter int ID_W    = $clog2(N_GHOST)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ghost_dir_scheduler_if.slave  bus
);

    state_e             state_q;
    logic [ID_W-1:0]    last_q;
    logic [ID_W-1:0]    id_q;
    logic [3:0]         cur_q;
    logic [3:0]         allowed_q;
    logic [1:0]         start_q;
    logic               valid_q;
    logic [3:0]         dir_q;
    logic [ID_W-1:0]    gid_q;
    logic [N_GHOST-1:0] ack_q;

    logic               rr_found_d;
    logic [ID_W-1:0]    rr_id_d;
    logic [ID_W-1:0]    rr_idx;
    logic [3:0]         rr_cur_d;
    logic [3:0]         rr_allowed_d;
    logic [3:0]         pick_dir;

    logic unused_random_hi;
    assign unused_random_hi = ^bus.i_random[3:2];

    // Round-robin: search starts one past the last served ghost so a
    // ghost that keeps requesting lets the others go first.
    always_comb begin
        rr_found_d = 1'b0;
        rr_id_d    = '0;
        rr_idx     = '0;
        for (int i = 1; i <= N_GHOST; i++) begin
            rr_idx = ID_W'((int'(last_q) + i) % N_GHOST);
            if (!rr_found_d && bus.i_req[rr_idx]) begin
                rr_found_d = 1'b1;
                rr_id_d    = rr_idx;
            end
        end
    end

    // Select the winning ghost's direction and mask from the flat buses.
    always_comb begin
        rr_cur_d     = '0;
        rr_allowed_d = '0;
        for (int g = 0; g < N_GHOST; g++) begin
            if (rr_id_d == ID_W'(g)) begin
                rr_cur_d     = bus.i_cur_dir[4*g +: 4];
                rr_allowed_d = bus.i_allowed[4*g +: 4];
            end
        end
    end

    ghost_dir_picker u_picker (
        .start_i   (start_q),
        .allowed_i (allowed_q),
        .cur_dir_i (cur_q),
        .dir_o     (pick_dir)
    );

    // Scheduler FSM; grant outputs default to 0 so they only carry data
    // in the single valid cycle. Reset in SAMPLE/PICK drops the transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            last_q    <= ID_W'(N_GHOST - 1);
            id_q      <= '0;
            cur_q     <= '0;
            allowed_q <= '0;
            start_q   <= '0;
            valid_q   <= 1'b0;
            dir_q     <= '0;
            gid_q     <= '0;
            ack_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            dir_q   <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (rr_found_d) begin
                        id_q      <= rr_id_d;
                        cur_q     <= rr_cur_d;
                        allowed_q <= rr_allowed_d;
                        state_q   <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    start_q <= bus.i_random[1:0];
                    state_q <= ST_PICK;
                end
                ST_PICK: begin
                    valid_q <= 1'b1;
                    dir_q   <= pick_dir;
                    gid_q   <= id_q;
                    ack_q   <= N_GHOST'(1) << id_q;
                    last_q  <= id_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_dir_valid = valid_q;
    assign bus.o_dir       = dir_q;
    assign bus.o_ghost_id  = gid_q;
    assign bus.o_ack       = ack_q;
    assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ghost_dir_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ghost_dir_scheduler
// Scoreboard bench for ghost_dir_scheduler. The driver issues directed
// scenarios followed by random traffic, and a transaction-level reference
// model pushes each expected grant (cycle, ghost, direction) into a queue.
// A separate monitor compares the DUT outputs every cycle against the
// queue head. Honours GHOST_NO_REVERSE_EN like the design.
// ---------------------------------------------------------------------------
module tb_ghost_dir_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        int         cyc;
        int         id;
        logic [3:0] dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ghost_dir_scheduler_if #(.N_GHOST(N), .ID_W(IW)) bus ();

    ghost_dir_scheduler #(.N_GHOST(N), .ID_W(IW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;
    bit   armed = 1'b0;

    // Reference model state: transaction-level bookkeeping only.
    int         acc_c     = -100;
    int         next_free = 0;
    int         last      = N - 1;
    int         cur_g     = 0;
    logic [3:0] lat_cur   = '0;
    logic [3:0] lat_alw   = '0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cnt, act, exp);
        end
    endtask

    // Direction rule from the spec: list open directions in rotation order,
    // drop the reverse when exclusion is on, fall back to the reverse.
    function automatic logic [3:0] modelDir(logic [3:0] cur, logic [3:0] alw, int start);
        int cands[$];
        int rev;
        logic [1:0] k;
        if (cur >= 4'd1 && cur <= 4'd4)
            rev = (cur % 2 == 1) ? int'(cur) + 1 : int'(cur) - 1;
        else
            rev = 0;
        for (int j = 0; j < 4; j++) begin
            k = 2'((start + j) % 4);
            if (alw[k]) cands.push_back(int'(k) + 1);
        end
        if (cands.size() == 0) return 4'd0;
`ifdef GHOST_NO_REVERSE_EN
        foreach (cands[i]) if (cands[i] != rev) return 4'(cands[i]);
`endif
        return 4'(cands[0]);
    endfunction

    // Drive one cycle of inputs (at negedge) and advance the model.
    task automatic applyStimulus(input logic [N-1:0] req, input logic [4*N-1:0] cur,
                                 input logic [4*N-1:0] alw, input logic [3:0] rnd,
                                 input logic r);
        int c;
        @(negedge clk);
        c = cnt;
        bus.i_req     = req;
        bus.i_cur_dir = cur;
        bus.i_allowed = alw;
        bus.i_random  = rnd;
        rst           = r;
        if (r) begin
            armed = 1'b1;
            if (acc_c >= 0 && c == acc_c + 2 && q.size() > 0) void'(q.pop_back());
            acc_c     = -100;
            last      = N - 1;
            next_free = c + 1;
        end else begin
            if (acc_c >= 0 && c == acc_c + 1)
                q.push_back('{cyc: acc_c + 3, id: cur_g,
                              dir: modelDir(lat_cur, lat_alw, int'(rnd[1:0]))});
            if (c >= next_free && req != '0) begin
                for (int i = 1; i <= N; i++) begin
                    int g;
                    g = (last + i) % N;
                    if (((req >> g) & 1) != 0) begin
                        cur_g   = g;
                        lat_cur = 4'(cur >> (4 * g));
                        lat_alw = 4'(alw >> (4 * g));
                        break;
                    end
                end
                acc_c     = c;
                next_free = c + 3;
                last      = cur_g;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus('0, 16'($urandom), 16'($urandom), 4'($urandom), 1'b0);
    endtask

    // One request from ghost g; allowed mask switches to alw_late after
    // acceptance to show the latched copy is used.
    task automatic txn(input int g, input logic [3:0] cur, input logic [3:0] alw,
                       input logic [3:0] alw_late, input logic [1:0] rnd);
        logic [4*N-1:0] cv, av, al;
        cv = 16'($urandom);
        av = 16'($urandom);
        cv[4*g +: 4] = cur;
        av[4*g +: 4] = alw;
        al = av;
        al[4*g +: 4] = alw_late;
        applyStimulus(N'(1) << g, cv, av, 4'($urandom), 1'b0);
        applyStimulus('0, cv, al, {2'($urandom), rnd}, 1'b0);
        applyStimulus('0, cv, al, 4'($urandom), 1'b0);
        idle(2);
    endtask

    // Monitor: compares DUT outputs to the scoreboard head every cycle.
    always @(posedge clk) begin
        #1;
        if (armed) begin
            bit   ev;
            bit   eb;
            exp_t e;
            ev = (q.size() > 0) && (q[0].cyc == cnt);
            eb = (acc_c >= 0) && ((cnt == acc_c + 1) || (cnt == acc_c + 2));
            checkOutput("busy", 32'(bus.o_busy), 32'(eb));
            checkOutput("valid", 32'(bus.o_dir_valid), 32'(ev));
            if (ev) begin
                e = q.pop_front();
                checkOutput("ghost_id", 32'(bus.o_ghost_id), 32'(e.id));
                checkOutput("dir", 32'(bus.o_dir), 32'(e.dir));
                checkOutput("ack", 32'(bus.o_ack), 32'(N'(1) << e.id));
            end else begin
                checkOutput("idle_outputs", {20'd0, bus.o_dir, 2'(bus.o_ghost_id), 4'(bus.o_ack)}, 32'd0);
            end
        end
    end

    initial begin
        bus.i_req     = '0;
        bus.i_cur_dir = '0;
        bus.i_allowed = '0;
        bus.i_random  = '0;

        applyStimulus('0, '0, '0, '0, 1'b1);
        applyStimulus('0, '0, '0, '0, 1'b1);
        idle(2);

        $display("[TB] single request");
        txn(0, 4'd1, 4'b1111, 4'b1111, 2'd1);
        $display("[TB] dead end and empty mask");
        for (int r = 0; r < 4; r++) txn(1, 4'd1, 4'b0010, 4'b0010, 2'(r));
        txn(2, 4'd3, 4'b0000, 4'b1111, 2'd2);
        txn(3, 4'd9, 4'b1010, 4'b0000, 2'd3);
        $display("[TB] input change after acceptance");
        txn(0, 4'd4, 4'b1111, 4'b0001, 2'd0);

        $display("[TB] fairness");
        applyStimulus('0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 16; i++)
            applyStimulus(4'b1111, 16'($urandom), 16'($urandom), 4'($urandom), 1'b0);
        idle(3);

        $display("[TB] reset mid-operation");
        applyStimulus(4'b0100, 16'($urandom), 16'($urandom), 4'($urandom), 1'b0);
        applyStimulus(4'b0100, 16'($urandom), 16'($urandom), 4'($urandom), 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus(4'b1111, 16'($urandom), 16'($urandom), 4'($urandom), 1'b0);
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] rq;
            rq = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            applyStimulus(rq, 16'($urandom), 16'($urandom), 4'($urandom),
                          ($urandom_range(0, 59) == 0));
        end
        idle(6);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ghost_dir_scheduler.md
GHOST_DIR_SCHEDULER -- requirements
Module: ghost_dir_scheduler

Interface
REQ-001 Parameter N_GHOST, default 4, number of ghost requesters (2..8).
REQ-002 Parameter ID_W, default 2, width of the ghost index, equal to clog2(N_GHOST).
REQ-003 Port i_clk  input  1  single clock for the whole block.
REQ-004 Port i_rst  input  1  reset, synchronous and active-high.
REQ-005 Port i_random  input  4  free-running output of the shared random source; only bits [1:0] are used.
REQ-006 Port i_req  input  N_GHOST  per-ghost level request for a new direction at an intersection.
REQ-007 Port i_cur_dir  input  4*N_GHOST  per-ghost current direction code, ghost g at bits [4g+3:4g].
REQ-008 Port i_allowed  input  4*N_GHOST  per-ghost open-path mask: bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT.
REQ-009 Port o_dir_valid  output  1  one-cycle pulse; o_dir and o_ghost_id are valid in that cycle.
REQ-010 Port o_dir  output  4  chosen direction code.
REQ-011 Port o_ghost_id  output  ID_W  index of the ghost being served.
REQ-012 Port o_ack  output  N_GHOST  one-hot, asserted in the same cycle as o_dir_valid.
REQ-013 Port o_busy  output  1  high in every state except IDLE.

Function
REQ-014 Direction codes: 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT; codes 5..15 are invalid inputs and are treated as NONE.
REQ-015 The FSM has three states: IDLE, SAMPLE and PICK.
REQ-016 IDLE: if any i_req bit is set, select a ghost round-robin starting at (last_served+1) mod N_GHOST, latch its id, cur_dir and allowed mask, and go to SAMPLE; otherwise stay in IDLE.
REQ-017 SAMPLE: latch i_random[1:0] as the start index (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT) and go to PICK.
REQ-018 PICK: scan index k=(start+j) mod 4 for j=0..3 and take the first k that is allowed and not the reverse; register the result, pulse o_dir_valid/o_ack, update last_served and return to IDLE.
REQ-019 Reverse pairs are UP<->DOWN and LEFT<->RIGHT; NONE has no reverse.
REQ-020 If the only allowed direction is the reverse, choose the reverse.
REQ-021 If the allowed mask is 0, output NONE; o_dir_valid still pulses.
REQ-022 Latency: o_dir_valid is asserted exactly 3 cycles after the IDLE cycle that accepts the request, so the throughput is at most 1 grant per 3 cycles.
REQ-023 Inputs are sampled only in the latch cycles; changes to i_cur_dir or i_allowed after acceptance are ignored.
REQ-024 If a request is dropped mid-transaction, the transaction still completes and delivers its result.
REQ-025 A ghost whose i_req stays high after o_ack is treated as a new request, and round-robin serves the other pending requesters first.
REQ-026 o_dir, o_ghost_id and o_ack hold their values only during the valid pulse; outside it they are 0.

Reset
REQ-027 While i_rst=1 at a clock edge: state goes to IDLE, last_served goes to N_GHOST-1 (so ghost 0 is first), all outputs go to 0 and latched fields are cleared.
REQ-028 A reset during SAMPLE or PICK aborts the transaction with no o_dir_valid pulse.

Configuration
REQ-029 Macro GHOST_NO_REVERSE_EN defined: the reverse exclusion of REQ-018/REQ-020 applies.
REQ-030 Macro GHOST_NO_REVERSE_EN undefined: the reverse direction is scanned like any other direction, and REQ-020 has no effect.

Structure
REQ-031 Package ghost_pkg holds the direction code constants, the mask bit positions, N_GHOST_DEFAULT and the reverse-direction function.
REQ-032 Sub-module ghost_dir_picker is a combinational block with inputs start index, allowed mask and current direction, and output the direction code; it is instantiated once.

Verification
REQ-033 Single request: i_req=0001, allowed=1111, cur=UP, random[1:0]=1 -> skip DOWN (reverse), o_dir=LEFT, id=0, valid 3 cycles after acceptance.
REQ-034 Dead end: allowed=0010, cur=UP -> o_dir=DOWN; with GHOST_NO_REVERSE_EN undefined and random=1 -> DOWN as well.
REQ-035 Empty mask: allowed=0000 -> o_dir=NONE, o_ack asserted.
REQ-036 Fairness: i_req=1111 held -> o_ghost_id sequence 0,1,2,3,0, valid pulses spaced 3 cycles apart.
REQ-037 Reset mid-operation: i_rst pulsed in the SAMPLE cycle -> no valid pulse, o_busy=0 next cycle, and the next grant goes to ghost 0.
REQ-038 Input change: i_allowed changes from 1111 to 0001 during PICK -> the result follows the latched 1111.
